// File: rtl/kernel_dispatcher_if.sv
// kernel_dispatcher_if: host enqueue, core dispatch and status bundle for the kernel dispatcher
interface kernel_dispatcher_if #(
  parameter int NUM_SIMD_CORES    = 4,
  parameter int THREAD_COUNT      = 8,
  parameter int LOG2_THREAD_COUNT = 3,
  parameter int QUEUE_DEPTH       = 4,
  parameter int PC_WIDTH          = 32
);
  logic                                   launch_kernel;
  logic                                   enq_valid;
  logic                                   enq_ready;
  logic [LOG2_THREAD_COUNT:0]             enq_num_threads;
  logic [PC_WIDTH-1:0]                    enq_pc;
  logic [NUM_SIMD_CORES-1:0]              core_done;
  logic [NUM_SIMD_CORES-1:0]              dispatch_valid;
  logic [PC_WIDTH*NUM_SIMD_CORES-1:0]     dispatch_pc;
  logic [THREAD_COUNT*NUM_SIMD_CORES-1:0] dispatch_mask;
  logic [NUM_SIMD_CORES-1:0]              core_busy;
  logic [$clog2(QUEUE_DEPTH+1)-1:0]       queue_count;
  logic                                   all_idle;
  logic                                   err_zero_threads;
  modport master (
    output launch_kernel, enq_valid, enq_num_threads, enq_pc, core_done,
    input  enq_ready, dispatch_valid, dispatch_pc, dispatch_mask, core_busy, queue_count, all_idle, err_zero_threads
  );
  modport slave (
    input  launch_kernel, enq_valid, enq_num_threads, enq_pc, core_done,
    output enq_ready, dispatch_valid, dispatch_pc, dispatch_mask, core_busy, queue_count, all_idle, err_zero_threads
  );
endinterface

// File: rtl/kernel_dispatcher.sv
// kernel_dispatcher: descriptor FIFO issuing kernels round-robin to free SIMD cores
module kernel_dispatcher #(
  parameter int NUM_SIMD_CORES    = 4,
  parameter int THREAD_COUNT      = 8,
  parameter int LOG2_THREAD_COUNT = 3,
  parameter int QUEUE_DEPTH       = 4,
  parameter int PC_WIDTH          = 32
) (
  input  logic               clk,
  input  logic               rst,
  kernel_dispatcher_if.slave bus
);
  localparam int CW = $clog2(QUEUE_DEPTH+1);
  localparam int AW = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
  localparam int SW = NUM_SIMD_CORES > 1 ? $clog2(NUM_SIMD_CORES) : 1;
  localparam int NW = LOG2_THREAD_COUNT + 1;
  logic [PC_WIDTH-1:0] qpc_q [QUEUE_DEPTH];
  logic [PC_WIDTH-1:0] qpc_d [QUEUE_DEPTH];
  logic [NW-1:0] qn_q [QUEUE_DEPTH];
  logic [NW-1:0] qn_d [QUEUE_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] rr_q, rr_d, sel, idx;
  logic [NUM_SIMD_CORES-1:0] busy_q, busy_d, valid_q, valid_d, sel_oh;
  logic [NUM_SIMD_CORES-1:0][PC_WIDTH-1:0] pc_q, pc_d;
  logic [NUM_SIMD_CORES-1:0][THREAD_COUNT-1:0] mask_q, mask_d;
  logic [THREAD_COUNT-1:0] head_mask;
  logic err_q, err_d, found, accept, push, pop;
  // first free core scanning upward from rr_q with wraparound
  always_comb begin
    found = 1'b0;
    sel = '0;
    idx = '0;
    for (int i = 0; i < NUM_SIMD_CORES; i++) begin
      idx = SW'((int'(rr_q) + i) % NUM_SIMD_CORES);
      if (!found && !busy_q[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
  end
  always_comb begin
    head_mask = '0;
    for (int i = 0; i < THREAD_COUNT; i++) head_mask[i] = i < int'(qn_q[rd_q]);
  end
  always_comb begin
    accept = bus.enq_valid && bus.enq_ready;
    push = accept && (bus.enq_num_threads != '0);
    pop = bus.launch_kernel && (cnt_q != '0) && found;
    sel_oh = NUM_SIMD_CORES'(1) << sel;
    qpc_d = qpc_q;
    qn_d = qn_q;
    if (push) begin
      qpc_d[wr_q] = bus.enq_pc;
      qn_d[wr_q] = bus.enq_num_threads;
    end
    wr_d = push ? (wr_q == AW'(QUEUE_DEPTH-1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d = pop ? (rd_q == AW'(QUEUE_DEPTH-1) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    busy_d = (busy_q & ~bus.core_done) | (pop ? sel_oh : '0);
    valid_d = pop ? sel_oh : '0;
    pc_d = pc_q;
    mask_d = mask_q;
    if (pop) begin
      pc_d[sel] = qpc_q[rd_q];
      mask_d[sel] = head_mask;
    end
    rr_d = pop ? (sel == SW'(NUM_SIMD_CORES-1) ? '0 : sel + 1'b1) : rr_q;
    err_d = err_q | (accept && bus.enq_num_threads == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      qpc_q <= '{default: '0};
      qn_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      rr_q <= '0;
      busy_q <= '0;
      valid_q <= '0;
      pc_q <= '0;
      mask_q <= '0;
      err_q <= 1'b0;
    end else begin
      qpc_q <= qpc_d;
      qn_q <= qn_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      rr_q <= rr_d;
      busy_q <= busy_d;
      valid_q <= valid_d;
      pc_q <= pc_d;
      mask_q <= mask_d;
      err_q <= err_d;
    end
  end
  assign bus.enq_ready = cnt_q < CW'(QUEUE_DEPTH);
  assign bus.queue_count = cnt_q;
  assign bus.all_idle = (cnt_q == '0) && (busy_q == '0);
  assign bus.dispatch_valid = valid_q;
  assign bus.core_busy = busy_q;
  assign bus.dispatch_pc = pc_q;
  assign bus.dispatch_mask = mask_q;
  assign bus.err_zero_threads = err_q;
endmodule

// File: tb/tb_kernel_dispatcher.sv
// tb_kernel_dispatcher: directed stimulus checked against a queue-based reference model every cycle
module tb_kernel_dispatcher;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  kernel_dispatcher_if bus ();
  kernel_dispatcher dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  int q_n [$];
  logic [31:0] q_pc [$];
  logic [3:0] m_busy, m_valid;
  logic [31:0] m_pc [4];
  logic [7:0] m_mask [4];
  int m_rr;
  bit m_err, m_on;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic enq(input int n, input logic [31:0] pc);
    bus.enq_valid = 1'b1;
    bus.enq_num_threads = 4'(n);
    bus.enq_pc = pc;
  endtask
  // reference model: plain queue of descriptors, busy bits and a round-robin pointer
  always @(posedge clk) begin : model
    int sel, n, c;
    logic [31:0] p;
    bit acc;
    if (rst) begin
      q_n.delete();
      q_pc.delete();
      m_busy = '0;
      m_valid = '0;
      m_rr = 0;
      m_err = 0;
      m_on = 1;
      for (int k = 0; k < 4; k++) begin
        m_pc[k] = '0;
        m_mask[k] = '0;
      end
    end else begin
      sel = -1;
      acc = bus.enq_valid && q_n.size() < 4;
      if (bus.launch_kernel && q_n.size() > 0)
        for (int i = 0; i < 4; i++) begin
          c = (m_rr + i) % 4;
          if (sel < 0 && !m_busy[c]) sel = c;
        end
      m_valid = '0;
      m_busy = m_busy & ~bus.core_done;
      if (sel >= 0) begin
        n = q_n.pop_front();
        p = q_pc.pop_front();
        m_pc[sel] = p;
        m_mask[sel] = n >= 8 ? 8'hFF : 8'((1 << n) - 1);
        m_busy[sel] = 1'b1;
        m_valid[sel] = 1'b1;
        m_rr = (sel + 1) % 4;
      end
      if (acc) begin
        if (bus.enq_num_threads == 0) m_err = 1;
        else begin
          q_n.push_back(int'(bus.enq_num_threads));
          q_pc.push_back(bus.enq_pc);
        end
      end
    end
  end
  always @(negedge clk) begin : compare
    logic [127:0] epc;
    logic [31:0] emk;
    if (m_on) begin
      for (int k = 0; k < 4; k++) begin
        epc[k*32+:32] = m_pc[k];
        emk[k*8+:8] = m_mask[k];
      end
      chk("cmp_valid", bus.dispatch_valid, m_valid);
      chk("cmp_busy", bus.core_busy, m_busy);
      chk("cmp_count", bus.queue_count, q_n.size());
      chk("cmp_ready", bus.enq_ready, q_n.size() < 4);
      chk("cmp_idle", bus.all_idle, q_n.size() == 0 && m_busy == 0);
      chk("cmp_err", bus.err_zero_threads, m_err);
      chk("cmp_pc", bus.dispatch_pc, epc);
      chk("cmp_mask", bus.dispatch_mask, emk);
    end
  end
  initial begin
    logic [7:0] em [4];
    logic [31:0] ep [4];
    em[0] = 8'h0F; em[1] = 8'h03; em[2] = 8'h7F; em[3] = 8'h07;
    ep[0] = 32'h0000_000E; ep[1] = 32'h8765_4321; ep[2] = 32'hABCD_EF01; ep[3] = 32'h1010_1010;
    bus.launch_kernel = 0;
    bus.enq_valid = 0;
    bus.enq_num_threads = 0;
    bus.enq_pc = 0;
    bus.core_done = 0;
    tick(); tick();
    rst = 0;
    chk("rst_ready", bus.enq_ready, 1);
    chk("rst_idle", bus.all_idle, 1);
    chk("rst_count", bus.queue_count, 0);
    chk("rst_valid", bus.dispatch_valid, 0);
    chk("rst_pc", bus.dispatch_pc, 0);
    chk("rst_mask", bus.dispatch_mask, 0);
    for (int i = 0; i < 4; i++) begin
      enq(i == 0 ? 4 : i == 1 ? 2 : i == 2 ? 7 : 3, ep[i]);
      tick();
    end
    chk("full_count", bus.queue_count, 4);
    chk("full_ready", bus.enq_ready, 0);
    enq(1, 32'h55);
    tick();
    bus.enq_valid = 0;
    chk("refused_count", bus.queue_count, 4);
    bus.launch_kernel = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("launch_valid", bus.dispatch_valid, 4'b0001 << i);
      chk("launch_mask", bus.dispatch_mask[i*8+:8], em[i]);
      chk("launch_pc", bus.dispatch_pc[i*32+:32], ep[i]);
    end
    chk("launch_busy", bus.core_busy, 4'b1111);
    enq(8, 32'h100);
    tick();
    bus.enq_valid = 0;
    tick();
    chk("bp_hold_valid", bus.dispatch_valid, 0);
    chk("bp_hold_count", bus.queue_count, 1);
    bus.core_done = 4'b0100;
    tick();
    bus.core_done = 0;
    chk("bp_done_valid", bus.dispatch_valid, 0);
    chk("bp_done_busy", bus.core_busy, 4'b1011);
    tick();
    chk("bp_disp_valid", bus.dispatch_valid, 4'b0100);
    chk("bp_disp_mask", bus.dispatch_mask[16+:8], 8'hFF);
    chk("bp_disp_pc", bus.dispatch_pc[64+:32], 32'h100);
    enq(5, 32'h200);
    bus.core_done = 4'b1001;
    tick();
    bus.enq_valid = 0;
    bus.core_done = 0;
    chk("rr_busy", bus.core_busy, 4'b0110);
    tick();
    chk("rr_valid", bus.dispatch_valid, 4'b1000);
    chk("rr_mask", bus.dispatch_mask[24+:8], 8'h1F);
    enq(0, 32'h999);
    tick();
    bus.enq_valid = 0;
    chk("zero_err", bus.err_zero_threads, 1);
    chk("zero_count", bus.queue_count, 0);
    tick();
    chk("zero_sticky", bus.err_zero_threads, 1);
    chk("zero_nodisp", bus.dispatch_valid, 0);
    enq(9, 32'h900);
    tick();
    bus.enq_valid = 0;
    tick();
    chk("sat_valid", bus.dispatch_valid, 4'b0001);
    chk("sat_mask", bus.dispatch_mask[0+:8], 8'hFF);
    chk("sat_pc", bus.dispatch_pc[0+:32], 32'h900);
    bus.launch_kernel = 0;
    enq(1, 32'hA);
    bus.core_done = 4'b0010;
    tick();
    bus.core_done = 0;
    enq(2, 32'hB);
    tick();
    chk("sim_pre_count", bus.queue_count, 2);
    chk("sim_pre_busy", bus.core_busy, 4'b1101);
    bus.launch_kernel = 1;
    enq(3, 32'hC);
    bus.core_done = 4'b0001;
    tick();
    bus.enq_valid = 0;
    bus.core_done = 0;
    chk("sim_count", bus.queue_count, 2);
    chk("sim_valid", bus.dispatch_valid, 4'b0010);
    chk("sim_busy", bus.core_busy, 4'b1110);
    chk("sim_mask", bus.dispatch_mask[8+:8], 8'h01);
    tick();
    chk("sim_next_valid", bus.dispatch_valid, 4'b0001);
    chk("sim_next_mask", bus.dispatch_mask[0+:8], 8'h03);
    bus.launch_kernel = 0;
    enq(4, 32'hD);
    tick();
    enq(5, 32'hE0);
    bus.core_done = 4'b0011;
    tick();
    bus.enq_valid = 0;
    bus.core_done = 0;
    chk("mid_count", bus.queue_count, 3);
    chk("mid_busy", bus.core_busy, 4'b1100);
    rst = 1;
    bus.core_done = 4'b1100;
    bus.launch_kernel = 1;
    tick();
    rst = 0;
    bus.core_done = 0;
    bus.launch_kernel = 0;
    chk("mrst_count", bus.queue_count, 0);
    chk("mrst_busy", bus.core_busy, 0);
    chk("mrst_idle", bus.all_idle, 1);
    chk("mrst_valid", bus.dispatch_valid, 0);
    chk("mrst_err", bus.err_zero_threads, 0);
    tick();
    chk("mrst_nodisp", bus.dispatch_valid, 0);
    for (int i = 0; i < 4; i++) begin
      enq(i + 1, 32'h1000 + 32'(i));
      tick();
    end
    bus.enq_valid = 0;
    bus.launch_kernel = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("thru_valid", bus.dispatch_valid, 4'b0001 << i);
    end
    chk("thru_count", bus.queue_count, 0);
    chk("thru_busy", bus.core_busy, 4'b1111);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
